// File: rtl/load_seq_pkg.sv
// Shared load policy for the scheduler load path: FSM states, batches per layer and load sizes.
// Pure declarations; no logic or latency of its own.
package load_seq_pkg;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_STREAM,
    ST_WAIT_START,
    ST_WAIT_BATCH,
    ST_WAIT_LAYER
  } state_t;

  // Highest batch index per layer (L0:8, L1:4, L2:1, L3:1 batches)
  localparam logic [2:0]  MAX_BATCH    [4] = '{3'd7, 3'd3, 3'd0, 3'd0};
  localparam logic [15:0] IFMAP_WORDS  [4] = '{16'd512, 16'd256, 16'd128, 16'd64};
  localparam logic [15:0] WEIGHT_WORDS [4] = '{16'd256, 16'd256, 16'd512, 16'd512};

  function automatic logic [15:0] load_len(input logic is_weight, input logic [1:0] layer);
    return is_weight ? WEIGHT_WORDS[layer] : IFMAP_WORDS[layer];
  endfunction

endpackage

// File: rtl/bram_write_stream.sv
// Turns accepted stream beats into sequential BRAM writes starting at address 0.
// Latency: 1 cycle beat-to-write; last flags the final write. s_ready high only while a load is armed.
module bram_write_stream #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              last
);

  localparam logic [ADDR_W:0] ONE = 1;

  logic            active;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] last_idx;

  assign s_ready = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active     <= 1'b0;
      cnt        <= '0;
      last_idx   <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      last       <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      last    <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        cnt      <= '0;
        last_idx <= len - ONE;
      end else if (active && s_valid) begin
        bram_we    <= 1'b1;
        bram_addr  <= cnt[ADDR_W-1:0];
        bram_wdata <= s_data;
        cnt        <= cnt + ONE;
        if (cnt == last_idx) begin
          active <= 1'b0;
          last   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/load_sequencer.sv
// Walks layer/batch order issuing ifmap/weight DMA loads into BRAM and raising the write-done levels.
// Latency: done 1 cycle after last write; req held until req_ready. LOAD_SEQ_PREFETCH_EN enables ping-pong weight prefetch.
module load_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_start,
  input  logic              batch_complete_signal,
  input  logic              all_batches_complete,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_is_weight,
  output logic [1:0]        req_layer,
  output logic [2:0]        req_batch,
  output logic [ADDR_W:0]   req_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              bram_we,
  output logic              bram_sel_weight,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              weight_bank,
  output logic              ifmap_write_done,
  output logic              weight_write_done,
  output logic              loader_busy,
  output logic              err_start_early
);
  import load_seq_pkg::*;

  localparam int LEN_W = ADDR_W + 1;

  state_t      state;
  logic [1:0]  ld_layer;
  logic [2:0]  ld_batch;
  logic        ld_is_weight;
  logic        ld_bank;
  logic        wr_last;
  logic [ADDR_W:0] cur_len;
  logic        accept;

  assign cur_len = LEN_W'(load_len(ld_is_weight, ld_layer));
  assign accept  = (state == ST_REQ) && req_valid && req_ready;

  // Request fields come straight from the load registers, which are frozen while req_valid is high
  assign req_is_weight   = req_valid & ld_is_weight;
  assign req_layer       = req_valid ? ld_layer : 2'd0;
  assign req_batch       = (req_valid && ld_is_weight) ? ld_batch : 3'd0;
  assign req_len         = req_valid ? cur_len : '0;
  assign loader_busy     = (state == ST_REQ && req_valid) || (state == ST_STREAM);
  assign bram_sel_weight = bram_we & ld_is_weight;

  bram_write_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_stream (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .len        (cur_len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .last       (wr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_REQ;
      ld_layer          <= 2'd0;
      ld_batch          <= 3'd0;
      ld_is_weight      <= 1'b0;
      ld_bank           <= 1'b0;
      req_valid         <= 1'b0;
      weight_bank       <= 1'b0;
      ifmap_write_done  <= 1'b0;
      weight_write_done <= 1'b0;
      err_start_early   <= 1'b0;
    end else begin
      if (sched_start && state != ST_WAIT_START)
        err_start_early <= 1'b1;
      case (state)
        ST_REQ: begin
          // Only reached with req_valid low straight out of reset
          if (!req_valid) begin
            req_valid <= 1'b1;
            if (ld_is_weight) weight_write_done <= 1'b0;
            else              ifmap_write_done  <= 1'b0;
          end else if (req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (wr_last) begin
            if (ld_is_weight) begin
              weight_write_done <= 1'b1;
              weight_bank       <= ld_bank;
              state             <= ST_WAIT_START;
            end else begin
              ifmap_write_done  <= 1'b1;
              weight_write_done <= 1'b0;
              ld_is_weight      <= 1'b1;
              ld_batch          <= 3'd0;
              req_valid         <= 1'b1;
              state             <= ST_REQ;
            end
          end
        end
        ST_WAIT_START: begin
          if (sched_start) begin
            if (ld_batch < MAX_BATCH[ld_layer]) begin
              ld_batch <= ld_batch + 3'd1;
`ifdef LOAD_SEQ_PREFETCH_EN
              ld_bank           <= ~ld_bank;
              weight_write_done <= 1'b0;
              req_valid         <= 1'b1;
              state             <= ST_REQ;
`else
              state <= ST_WAIT_BATCH;
`endif
            end else begin
              state <= ST_WAIT_LAYER;
            end
          end
        end
        ST_WAIT_BATCH: begin
          if (batch_complete_signal) begin
            ld_bank           <= 1'b0;
            weight_write_done <= 1'b0;
            req_valid         <= 1'b1;
            state             <= ST_REQ;
          end
        end
        ST_WAIT_LAYER: begin
          if (all_batches_complete) begin
            ld_layer          <= ld_layer + 2'd1;
            ld_batch          <= 3'd0;
            ld_bank           <= 1'b0;
            ld_is_weight      <= 1'b0;
            weight_bank       <= 1'b0;
            ifmap_write_done  <= 1'b0;
            weight_write_done <= 1'b0;
            req_valid         <= 1'b1;
            state             <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: a host model answers each DMA request and checks BRAM writes and done timing.
module tb_load_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sched_start = 1'b0;
  logic              batch_complete_signal = 1'b0;
  logic              all_batches_complete = 1'b0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic              req_is_weight;
  logic [1:0]        req_layer;
  logic [2:0]        req_batch;
  logic [ADDR_W:0]   req_len;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              bram_we;
  logic              bram_sel_weight;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              weight_bank;
  logic              ifmap_write_done;
  logic              weight_write_done;
  logic              loader_busy;
  logic              err_start_early;

  int checks = 0;
  int errors = 0;

  load_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .sched_start           (sched_start),
    .batch_complete_signal (batch_complete_signal),
    .all_batches_complete  (all_batches_complete),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_is_weight         (req_is_weight),
    .req_layer             (req_layer),
    .req_batch             (req_batch),
    .req_len               (req_len),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .s_data                (s_data),
    .bram_we               (bram_we),
    .bram_sel_weight       (bram_sel_weight),
    .bram_addr             (bram_addr),
    .bram_wdata            (bram_wdata),
    .weight_bank           (weight_bank),
    .ifmap_write_done      (ifmap_write_done),
    .weight_write_done     (weight_write_done),
    .loader_busy           (loader_busy),
    .err_start_early       (err_start_early)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  typedef struct {
    bit pre_start;
    bit pre_abc;
    bit w;
    int layer;
    int batch;
    int len;
    bit gappy;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 7 + 4660);
  endfunction

  function automatic logic done_sig(input bit w);
    return w ? weight_write_done : ifmap_write_done;
  endfunction

  function automatic int out_ones();
    return $countones({req_valid, req_is_weight, req_layer, req_batch, req_len, s_ready, bram_we,
                       bram_sel_weight, bram_addr, bram_wdata, weight_bank, ifmap_write_done,
                       weight_write_done, loader_busy, err_start_early});
  endfunction

  task automatic pulse(input int sel);
    @(posedge clk); #1;
    sched_start           = (sel == 0);
    batch_complete_signal = (sel == 1);
    all_batches_complete  = (sel == 2);
    @(posedge clk); #1;
    sched_start = 0; batch_complete_signal = 0; all_batches_complete = 0;
  endtask

  task automatic next_batch();
    pulse(0);
`ifndef LOAD_SEQ_PREFETCH_EN
    pulse(1);
`endif
  endtask

  task automatic serve_load(input string tag, input bit w, input int layer, input int batch,
                            input int len, input bit gappy, input bit poke);
    int n = 0;
    int sent = 0;
    int wr = 0;
    int bad = 0;
    int cyc = 0;
    logic dl = 1'b1;
    logic rdy;
    do begin @(negedge clk); n++; end while (!req_valid && n < 200);
    check({tag, "_req_seen"}, req_valid, 1);
    if (!req_valid) return;
    check({tag, "_req_w"}, req_is_weight, w);
    check({tag, "_req_layer"}, req_layer, layer);
    check({tag, "_req_batch"}, req_batch, batch);
    check({tag, "_req_len"}, req_len, len);
    check({tag, "_done_low"}, done_sig(w), 0);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = pat(0);
    while (wr < len && cyc < 4000) begin
      @(negedge clk);
      if (bram_we) begin
        if (bram_addr != wr[ADDR_W-1:0] || bram_wdata != pat(wr) || bram_sel_weight != w) bad++;
        wr++;
        if (wr == len) dl = done_sig(w);
      end
      rdy = s_ready;
      if (wr < len) begin
        @(posedge clk);
        if (s_valid && rdy) sent++;
        #1;
        cyc++;
        s_valid     = (sent < len) && (!gappy || (cyc % 2 == 0));
        s_data      = pat(sent);
        sched_start = poke && (cyc == 5);
      end
    end
    s_valid = 1'b0;
    sched_start = 1'b0;
    check({tag, "_we_count"}, wr, len);
    check({tag, "_write_bad"}, bad, 0);
    check({tag, "_done_at_last_we"}, dl, 0);
    @(negedge clk);
    check({tag, "_done_rise"}, done_sig(w), 1);
    check({tag, "_no_extra_we"}, bram_we, 0);
  endtask

  vec_t tbl[12];

  initial begin
    int n;
    tbl[0]  = '{0, 0, 0, 0, 0, 512, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 256, 0};
    for (int b = 1; b <= 7; b++) tbl[b + 1] = '{1, 0, 1, 0, b, 256, (b == 3)};
    tbl[9]  = '{1, 1, 0, 1, 0, 256, 1};
    tbl[10] = '{0, 0, 1, 1, 0, 256, 0};
    tbl[11] = '{1, 0, 1, 1, 1, 256, 0};

    repeat (3) @(negedge clk);
    check("reset_outputs_zero", out_ones(), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].pre_start) begin
        pulse(0);
`ifdef LOAD_SEQ_PREFETCH_EN
        if (!tbl[i].pre_abc) begin
          @(negedge clk);
          check($sformatf("v%0d_prefetch_req_next", i), req_valid, 1);
        end else begin
          repeat (3) begin @(negedge clk); check($sformatf("v%0d_req_idle", i), req_valid, 0); end
          pulse(2);
        end
`else
        repeat (3) begin @(negedge clk); check($sformatf("v%0d_req_idle", i), req_valid, 0); end
        pulse(tbl[i].pre_abc ? 2 : 1);
`endif
      end
      serve_load($sformatf("v%0d", i), tbl[i].w, tbl[i].layer, tbl[i].batch, tbl[i].len,
                 tbl[i].gappy, 1'b0);
      check($sformatf("v%0d_ifmap_done", i), ifmap_write_done, 1);
      if (tbl[i].w) begin
        check($sformatf("v%0d_weight_done", i), weight_write_done, 1);
`ifdef LOAD_SEQ_PREFETCH_EN
        check($sformatf("v%0d_bank", i), weight_bank, tbl[i].batch % 2);
`else
        check($sformatf("v%0d_bank", i), weight_bank, 0);
`endif
      end
    end
    check("no_early_start_yet", err_start_early, 0);

    // Start during STREAM is flagged and must not advance the batch
    next_batch();
    serve_load("early", 1'b1, 1, 2, 256, 1'b0, 1'b1);
    check("err_start_early_set", err_start_early, 1);
    next_batch();
    serve_load("after_early", 1'b1, 1, 3, 256, 1'b0, 1'b0);

    // Last L1 batch consumed, next layer ifmap begins; reset lands mid-stream
    pulse(0);
    pulse(2);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_valid && n < 200);
    check("l2_req_seen", req_valid, 1);
    check("l2_req_layer", req_layer, 2);
    check("l2_req_len", req_len, 128);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    s_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midstream_reset_outputs_zero", out_ones(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    serve_load("post_rst", 1'b0, 0, 0, 512, 1'b0, 1'b0);
    check("post_rst_err_clear", err_start_early, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
